// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch front end.
package cpu_pkg;

    typedef logic [31:0] virt_t;

    localparam virt_t RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        PCG_RUN  = 2'd0,
        PCG_PEND = 2'd1,
        PCG_DS   = 2'd2
    } pcg_state_e;

endpackage

// File: rtl/pc_gen.sv
// Fetch PC generator with MIPS delay-slot aware branch prediction
// and commit/BPU redirects.
module pc_gen #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_ready,
    input  logic        bpu_pred_valid,
    input  logic        bpu_taken,
    input  logic [31:0] bpu_target,
    input  logic        bpu_correct,
    input  logic [31:0] bpu_correct_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        pc_is_ds,
    output logic        adel,
    output logic        flush
);

    import cpu_pkg::*;

    pcg_state_e state_q, state_d;
    virt_t      pc_q, pc_d;
    virt_t      tgt_q, tgt_d;
    virt_t      pc_inc;
    logic       valid_q;
    logic       fire;
    logic       redirect;
    logic       take;

    assign fire     = valid_q & fetch_ready;
    assign redirect = exc_redirect | bpu_correct;
    assign pc_inc   = pc_q + 32'd4;

    // A prediction seen in DS belongs to the delay slot itself.
    assign take = (state_q == PCG_RUN) & bpu_pred_valid & bpu_taken;

    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        state_d = state_q;
        if (exc_redirect) begin
            pc_d    = exc_target;
            tgt_d   = '0;
            state_d = PCG_RUN;
        end else if (bpu_correct) begin
            pc_d    = bpu_correct_target;
            tgt_d   = '0;
            state_d = PCG_RUN;
        end else begin
            unique case (state_q)
                PCG_RUN: begin
                    if (take) begin
                        if (fire) begin
                            pc_d    = bpu_target;
                            state_d = PCG_DS;
                        end else begin
                            tgt_d   = bpu_target;
                            state_d = PCG_PEND;
                        end
                    end else if (fire) begin
                        pc_d = pc_inc;
                    end
                end
                PCG_PEND: begin
                    if (fire) begin
                        pc_d    = tgt_q;
                        tgt_d   = '0;
                        state_d = PCG_DS;
                    end
                end
                PCG_DS: begin
                    state_d = PCG_RUN;
                    if (fire) begin
                        pc_d = pc_inc;
                    end
                end
                default: begin
                    state_d = PCG_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            state_q <= PCG_RUN;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
            valid_q <= 1'b1;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = valid_q;
    assign pc_is_ds = valid_q & (take | (state_q == PCG_PEND));
    assign adel     = (pc_q[1:0] != 2'b00);
    assign flush    = ~reset & redirect;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected fetch addresses are queued
// as stimulus is driven and matched against each observed fire.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic        bpu_pred_valid;
    logic        bpu_taken;
    logic [31:0] bpu_target;
    logic        bpu_correct;
    logic [31:0] bpu_correct_target;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_is_ds;
    logic        adel;
    logic        flush;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [31:0] exp_q[$];

    pc_gen dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_ready        (fetch_ready),
        .bpu_pred_valid     (bpu_pred_valid),
        .bpu_taken          (bpu_taken),
        .bpu_target         (bpu_target),
        .bpu_correct        (bpu_correct),
        .bpu_correct_target (bpu_correct_target),
        .exc_redirect       (exc_redirect),
        .exc_target         (exc_target),
        .pc                 (pc),
        .pc_valid           (pc_valid),
        .pc_is_ds           (pc_is_ds),
        .adel               (adel),
        .flush              (flush)
    );

    always #5 clk = ~clk;

    // Every fire must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset === 1'b0 && pc_valid === 1'b1 && fetch_ready === 1'b1) begin
            tot_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL fire_order: unexpected fire pc=%h", pc);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e)
                    $display("FAIL fire_pc: got %h exp %h", pc, e);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic pv, input logic tk,
                         input logic [31:0] t, input logic cr,
                         input logic [31:0] ct, input logic ex,
                         input logic [31:0] et);
        fetch_ready        = rdy;
        bpu_pred_valid     = pv;
        bpu_taken          = tk;
        bpu_target         = t;
        bpu_correct        = cr;
        bpu_correct_target = ct;
        exc_redirect       = ex;
        exc_target         = et;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'hBFC00000) $display("FAIL rst_pc: got %h exp %h", pc, 32'hBFC00000);
        else pass_cnt++;
        tot_cnt++;
        if (pc_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", pc_valid);
        else pass_cnt++;
        tot_cnt++;
        if (pc_is_ds !== 1'b0) $display("FAIL rst_ds: got %b exp 0", pc_is_ds);
        else pass_cnt++;
        tot_cnt++;
        if (flush !== 1'b0) $display("FAIL rst_flush: got %b exp 0", flush);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_seq();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00004);
        exp_q.push_back(32'hBFC00008);
        tick();
        @(negedge clk);
        tot_cnt++;
        if (pc_valid !== 1'b1) $display("FAIL seq_valid: got %b exp 1", pc_valid);
        else pass_cnt++;
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL seq_drain: got %0d left exp 0", exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_taken();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h80000100);
        @(negedge clk);
        tot_cnt++;
        if (flush !== 1'b1) $display("FAIL tk_flush: got %b exp 1", flush);
        else pass_cnt++;
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000100);
        tick();
        drive(1, 1, 1, 32'h80000400, 0, 0, 0, 0);
        exp_q.push_back(32'h80000104);
        @(negedge clk);
        tot_cnt++;
        if (pc_is_ds !== 1'b1) $display("FAIL tk_ds: got %b exp 1", pc_is_ds);
        else pass_cnt++;
        tick();
        drive(1, 1, 1, 32'h80000900, 0, 0, 0, 0);
        exp_q.push_back(32'h80000400);
        @(negedge clk);
        tot_cnt++;
        if (pc_is_ds !== 1'b0) $display("FAIL tk_tgt_ds: got %b exp 0", pc_is_ds);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'h80000404) $display("FAIL tk_after: got %h exp %h", pc, 32'h80000404);
        else pass_cnt++;
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL tk_drain: got %0d left exp 0", exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_pend();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h80000100);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000100);
        tick();
        drive(0, 1, 1, 32'h80000400, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc_is_ds !== 1'b1) $display("FAIL pd_ds0: got %b exp 1", pc_is_ds);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'h80000104) $display("FAIL pd_hold: got %h exp %h", pc, 32'h80000104);
        else pass_cnt++;
        tot_cnt++;
        if (pc_is_ds !== 1'b1) $display("FAIL pd_ds1: got %b exp 1", pc_is_ds);
        else pass_cnt++;
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000104);
        tick();
        exp_q.push_back(32'h80000400);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'h80000404) $display("FAIL pd_after: got %h exp %h", pc, 32'h80000404);
        else pass_cnt++;
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL pd_drain: got %0d left exp 0", exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_correct_pend();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h80000100);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000100);
        tick();
        drive(0, 1, 1, 32'h80000400, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h80000200, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (flush !== 1'b1) $display("FAIL cr_flush: got %b exp 1", flush);
        else pass_cnt++;
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000200);
        @(negedge clk);
        tot_cnt++;
        if (pc_is_ds !== 1'b0) $display("FAIL cr_ds: got %b exp 0", pc_is_ds);
        else pass_cnt++;
        tot_cnt++;
        if (flush !== 1'b0) $display("FAIL cr_flush_end: got %b exp 0", flush);
        else pass_cnt++;
        tick();
        exp_q.push_back(32'h80000204);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'h80000208) $display("FAIL cr_after: got %h exp %h", pc, 32'h80000208);
        else pass_cnt++;
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL cr_drain: got %0d left exp 0", exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_both_redirect();
        drive(0, 0, 0, 0, 1, 32'h80000300, 1, 32'hBFC00380);
        @(negedge clk);
        tot_cnt++;
        if (flush !== 1'b1) $display("FAIL both_flush: got %b exp 1", flush);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'hBFC00380) $display("FAIL both_pc: got %h exp %h", pc, 32'hBFC00380);
        else pass_cnt++;
        tot_cnt++;
        if (flush !== 1'b0) $display("FAIL both_once: got %b exp 0", flush);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap_adel();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'hFFFFFFFC);
        @(negedge clk);
        tot_cnt++;
        if (adel !== 1'b0) $display("FAIL wr_adel0: got %b exp 0", adel);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'h00000000) $display("FAIL wr_pc: got %h exp %h", pc, 32'h0);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h80000002);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000002);
        @(negedge clk);
        tot_cnt++;
        if (adel !== 1'b1) $display("FAIL wr_adel1: got %b exp 1", adel);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'h80000006) $display("FAIL wr_mis: got %h exp %h", pc, 32'h80000006);
        else pass_cnt++;
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL wr_drain: got %0d left exp 0", exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_pend();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h80000100);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h80000100);
        tick();
        drive(0, 1, 1, 32'h80000400, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'hBFC00000) $display("FAIL rp_pc: got %h exp %h", pc, 32'hBFC00000);
        else pass_cnt++;
        tot_cnt++;
        if (pc_is_ds !== 1'b0) $display("FAIL rp_ds: got %b exp 0", pc_is_ds);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00004);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (pc !== 32'hBFC00008) $display("FAIL rp_after: got %h exp %h", pc, 32'hBFC00008);
        else pass_cnt++;
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL rp_drain: got %0d left exp 0", exp_q.size());
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_seq();
        test_taken();
        test_pend();
        test_correct_pend();
        test_both_redirect();
        test_wrap_adel();
        test_reset_pend();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 fetch_ready  in  1  fetch stage accepts pc this cycle.
REQ-005 bpu_pred_valid  in  1  BPU prediction valid for the pc that fired in the previous cycle.
REQ-006 bpu_taken  in  1  predicted taken.
REQ-007 bpu_target  in  32  predicted target.
REQ-008 bpu_correct  in  1  BPU correction pulse (mispredict).
REQ-009 bpu_correct_target  in  32  correction target.
REQ-010 exc_redirect  in  1  commit-stage exception/ERET flush.
REQ-011 exc_target  in  32  exception/ERET vector.
REQ-012 pc  out  32  current fetch address, also the BPU lookup pc.
REQ-013 pc_valid  out  1  pc is valid to fetch and BPU.
REQ-014 pc_is_ds  out  1  pc is a branch delay slot.
REQ-015 adel  out  1  pc[1:0] != 0.
REQ-016 flush  out  1  one-cycle pulse: younger in-flight fetches are discarded.

Function
REQ-017 Fire is defined as pc_valid && fetch_ready; pc SHALL change only on fire or on redirect.
REQ-018 Next-pc priority SHALL be exc_redirect > bpu_correct > pending/accepted taken prediction > pc+4.
REQ-019 Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 without a flag.
REQ-020 States: RUN (sequential), PEND (taken prediction held and delay slot not yet fired), DS (delay slot fired and its prediction still due).
REQ-021 RUN, when bpu_pred_valid && bpu_taken and the last fire was not a delay slot, SHALL capture bpu_target:
- if the current pc (delay slot) fires in the same cycle: next pc = bpu_target, state DS;
- otherwise: state PEND.
REQ-022 PEND on fire: next pc = held target, state DS; without fire, hold pc and target.
REQ-023 DS: bpu_pred_valid in this state refers to the delay slot and SHALL be ignored; state RUN after one cycle.
REQ-024 Not-taken or invalid prediction in RUN SHALL follow pc+4 on fire.
REQ-025 pc_is_ds SHALL be 1 while pc is the delay slot of an accepted taken prediction (RUN-capture cycle or PEND).
REQ-026 exc_redirect or bpu_correct SHALL apply regardless of fetch_ready:
- next pc = the respective target;
- state RUN; discard any held target;
- flush = 1 the same cycle.
REQ-027 A bpu_correct pc is the post-delay-slot target; pc_gen SHALL NOT insert a delay slot after a correction.
REQ-028 Simultaneous exc_redirect and bpu_correct: exc_target wins and flush pulses once.
REQ-029 A redirect arriving in PEND or DS SHALL cancel it with no late jump to the old target.
REQ-030 adel SHALL be combinational from pc; pc_gen does not block fetch of a misaligned pc.

Reset
REQ-031 During reset: pc = RESET_PC, state RUN, held target = 0.
REQ-032 Output reset values: pc_valid = 0, pc_is_ds = 0, flush = 0.
REQ-033 pc_valid SHALL be 1 from the first cycle after reset deasserts.
REQ-034 Reset mid-PEND SHALL discard the held target.

Structure
REQ-035 RESET_PC and the pc_gen state enum SHALL be in the shared cpu package alongside virt_t.
REQ-036 No sub-module: one 32-bit adder, state register, and target register only.

Verification
REQ-037 Reset release, fetch_ready=1 for 3 cycles -> pc BFC00000, BFC00004, BFC00008.
REQ-038 Fire 0x80000100, next cycle bpu_taken target 0x80000400 with ready=1 -> pc 0x80000104 (pc_is_ds=1), then 0x80000400.
REQ-039 Same as REQ-038 with ready=0 for 2 cycles at 0x80000104 -> pc holds in PEND, then 0x80000400 after fire.
REQ-040 bpu_correct target 0x80000200 while in PEND -> flush=1, pc 0x80000200, old target never issued.
REQ-041 exc_redirect 0xBFC00380 with bpu_correct same cycle -> pc 0xBFC00380, one flush pulse.
REQ-042 pc 0xFFFFFFFC fires -> pc 0x00000000; exc_target 0x80000002 -> adel=1.
